// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive FIFO defaults and the count-width helper.
package uart_pkg;
  localparam int DATA_BITS_DEF = 8;
  localparam int DEPTH_DEF = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with asynchronous active-low reset.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s2_q, s1_q} <= '0;
    else {s2_q, s1_q} <= {s1_q, d};
  assign q = s2_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT FIFO capturing one UART character per rx_done rising edge.
// Define UART_RXF_ERR_EN to store a per-entry parity error bit and drive rd_err.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done,
  input  logic [DATA_BITS-1:0]       rx_dout,
  input  logic                       correct,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rd_err,
  output logic                       empty,
  output logic                       full,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  input  logic                       ovf_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
`ifdef UART_RXF_ERR_EN
  localparam int EW = DATA_BITS + 1;
`else
  localparam int EW = DATA_BITS;
`endif
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_ent;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, dly_q, dly_d, sync_out, wr, rd, do_wr, drop;
  uart_sync2 u_sync (.clk(clk), .reset(reset), .d(rx_done), .q(sync_out));
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign overflow = ovf_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q][DATA_BITS-1:0];
`ifdef UART_RXF_ERR_EN
  assign wr_ent = {~correct, rx_dout};
  assign rd_err = empty ? 1'b0 : mem_q[rd_ptr_q][DATA_BITS];
`else
  logic unused_correct;
  assign unused_correct = correct;
  assign wr_ent = rx_dout;
  assign rd_err = 1'b0;
`endif
  // A full FIFO still accepts a write when the same edge pops.
  always_comb begin
    wr = sync_out & ~dly_q;
    rd = rd_en & ~empty;
    do_wr = wr & (~full | rd);
    drop = wr & full & ~rd;
    dly_d = sync_out;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(do_wr) - CW'(rd);
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dly_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  always_ff @(posedge clk)
    if (do_wr) mem_q[wr_ptr_q] <= wr_ent;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (default 8x16).
module tb_uart_rx_fifo;
  logic clk = 1'b0, reset = 1'b0, rx_done = 1'b0, correct = 1'b1, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] rx_dout = '0, rd_data;
  logic rd_err, empty, full, overflow;
  logic [4:0] count;
  int n_tests = 0, n_fail = 0;
  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_dout(rx_dout), .correct(correct),
    .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic c);
    rx_done = 1'b1;
    rx_dout = d;
    correct = c;
    tick(3);
    rx_done = 1'b0;
    tick(3);
  endtask
  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    tick(2);
    reset = 1'b1;
    tick();
    rx_done = 1'b1;
    rx_dout = 8'hA5;
    correct = 1'b1;
    tick();
    chk("a5_edge1_empty", 32'(empty), 1);
    tick();
    chk("a5_edge2_empty", 32'(empty), 1);
    tick();
    chk("a5_edge3_empty", 32'(empty), 0);
    chk("a5_rd_data", 32'(rd_data), 32'hA5);
    chk("a5_rd_err", 32'(rd_err), 0);
    chk("a5_count", 32'(count), 1);
    tick(4);
    chk("held_one_write", 32'(count), 1);
    rx_done = 1'b0;
    tick(3);
    pop();
    chk("pop_a5_empty", 32'(empty), 1);
    chk("pop_a5_rd_data", 32'(rd_data), 0);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_ovf", 32'(overflow), 0);
    send(8'hFF, 1'b1);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("order_%0d", i), 32'(rd_data), 32'(i));
      pop();
    end
    chk("drain_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b1);
    rx_done = 1'b1;
    rx_dout = 8'h77;
    tick(2);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rx_done = 1'b0;
    chk("wrpop_count", 32'(count), 16);
    chk("wrpop_ovf", 32'(overflow), 0);
    chk("wrpop_head", 32'(rd_data), 32'h11);
    tick(3);
    for (int i = 0; i < 15; i++) pop();
    chk("wrpop_last", 32'(rd_data), 32'h77);
    pop();
    chk("wrpop_empty", 32'(empty), 1);
    rx_done = 1'b1;
    rx_dout = 8'h5A;
    rd_en = 1'b1;
    tick(3);
    rd_en = 1'b0;
    rx_done = 1'b0;
    chk("empty_rd_wr_count", 32'(count), 1);
    chk("empty_rd_wr_data", 32'(rd_data), 32'h5A);
    tick(3);
    pop();
    send(8'h3C, 1'b0);
    chk("err_data", 32'(rd_data), 32'h3C);
`ifdef UART_RXF_ERR_EN
    chk("err_flag", 32'(rd_err), 1);
`else
    chk("err_flag", 32'(rd_err), 0);
`endif
    pop();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rd_empty_count_%0d", i), 32'(count), 0);
      chk($sformatf("rd_empty_data_%0d", i), 32'(rd_data), 0);
    end
    rd_en = 1'b0;
    rx_done = 1'b1;
    rx_dout = 8'h99;
    tick(2);
    reset = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    tick();
    reset = 1'b1;
    chk("post_rel_count", 32'(count), 0);
    tick(2);
    chk("post_rel_edge2", 32'(count), 0);
    tick();
    chk("post_rel_write", 32'(count), 1);
    chk("post_rel_data", 32'(rd_data), 32'h99);
    tick(4);
    chk("post_rel_single", 32'(count), 1);
    rx_done = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, width of one received character.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_done  input  1  receiver frame-complete level, asynchronous to clk.
REQ-006 SHALL have port rx_dout  input  DATA_BITS  received character, stable while rx_done high.
REQ-007 SHALL have port correct  input  1  receiver parity-check result, 1 = parity good.
REQ-008 SHALL have port rd_en  input  1  pop request from consumer.
REQ-009 SHALL have port rd_data  output  DATA_BITS  head entry, first-word-fall-through.
REQ-010 SHALL have port rd_err  output  1  parity error flag of head entry.
REQ-011 SHALL have port empty  output  1  no entries stored.
REQ-012 SHALL have port full  output  1  DEPTH entries stored.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  entries stored.
REQ-014 SHALL have port overflow  output  1  sticky: a character was dropped.
REQ-015 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-016 SHALL pass rx_done through a 2-flop synchronizer, then a third flop for edge detection; write pulse = sync_out AND NOT delayed.
REQ-017 SHALL write on the clk edge where the write pulse is high, i.e. the 3rd rising clk edge after rx_done is first sampled high; empty and count update on that edge.
REQ-018 SHALL store rx_dout together with err = NOT correct, both sampled on the write edge.
REQ-019 SHALL write exactly one entry per rx_done rising edge; rx_done held high writes nothing further.
REQ-020 SHALL present the entry at rd_ptr on rd_data/rd_err combinationally when not empty; both SHALL read 0 when empty.
REQ-021 SHALL pop on a clk edge with rd_en high and empty low; rd_en while empty is ignored with no state change.
REQ-022 SHALL drop the write when full and no pop occurs that cycle, set overflow, and leave pointers and count unchanged.
REQ-023 SHALL perform both write and pop when full with a simultaneous pop; count stays DEPTH.
REQ-024 SHALL perform only the write when empty with a simultaneous rd_en; no fall-through in the same cycle.
REQ-025 SHALL use pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0; full = (count == DEPTH), empty = (count == 0).
REQ-026 SHALL clear overflow on an ovf_clr edge; a drop in the same cycle wins, so overflow stays 1.

Reset
REQ-027 SHALL on reset low immediately force count=0, empty=1, full=0, overflow=0, pointers=0, all synchronizer flops=0, rd_data=0, rd_err=0.
REQ-028 SHALL not clear memory contents; they are unobservable while empty.
REQ-029 SHALL discard any write in flight through the synchronizer when reset asserts mid-operation; a still-high rx_done after release produces one write.

Configuration
REQ-030 SHALL, with UART_RXF_ERR_EN defined, store the err bit per entry and drive rd_err per REQ-020.
REQ-031 SHALL, without UART_RXF_ERR_EN, store no err bit, ignore correct, and tie rd_err to 0.

Structure
REQ-032 SHALL take DATA_BITS and DEPTH defaults and the count-width constant from shared package uart_pkg.
REQ-033 SHALL implement the 2-flop synchronizer as sub-module uart_sync2 with clk, reset, d, q.

Verification
REQ-034 Reset, then rx_done high with rx_dout=8'hA5, correct=1 -> empty falls on 3rd clk edge; rd_data=8'hA5, rd_err=0, count=1.
REQ-035 Write 16 characters 8'h00..8'h0F -> full=1; 17th rx_done pulse -> overflow=1, count=16; pops return 8'h00..8'h0F in order, then empty=1.
REQ-036 Full FIFO, rx_done edge on the same clk edge as rd_en -> count stays 16, overflow stays 0, last entry is the new character.
REQ-037 Write 8'h3C with correct=0 under UART_RXF_ERR_EN -> rd_err=1; same stimulus without the macro -> rd_err=0.
REQ-038 rd_en held high while empty for 5 cycles -> count stays 0 and rd_data stays 0; reset pulse with rx_done in synchronizer -> count=0 after release.
